// File: rtl/conv_scan_ctrl_pkg.sv
// Shared frame geometry defaults and sizing helpers for the convolution scan controller.
package conv_scan_ctrl_pkg;
   localparam int IMG_W_DEF = 320;
   localparam int IMG_H_DEF = 240;
   localparam int AW_DEF    = 17;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/conv_scan_ctrl_scan_counter.sv
// Raster-order x/y counters plus a running linear address, so no y*IMG_W multiply is needed.
module scan_counter
   import conv_scan_ctrl_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          en,
   output logic [AW-1:0] addr,
   output logic          last_px,
   output logic          edge_px
);
   localparam int XW = cnt_width(IMG_W);
   localparam int YW = cnt_width(IMG_H);
   localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

   logic [XW-1:0] x;
   logic [YW-1:0] y;

   assign last_px = (x == X_MAX) && (y == Y_MAX);
   assign edge_px = (x == '0) || (x == X_MAX) || (y == '0) || (y == Y_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (clear) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else if (en) begin
         // The linear address follows x one-for-one and returns to 0 after the final pixel.
         addr <= last_px ? '0 : addr + AW'(1);
         if (x == X_MAX) begin
            x <= '0;
            y <= (y == Y_MAX) ? '0 : y + YW'(1);
         end else begin
            x <= x + XW'(1);
         end
      end
   end
endmodule

// File: rtl/conv_scan_ctrl.sv
// Walks the processing buffer in raster order and issues one-cycle-latency ALU writes to the frame buffer.
module conv_scan_ctrl
   import conv_scan_ctrl_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic          CLK100MHZ,
   input  logic          rst_n,
   input  logic          frame_start,
   input  logic          stall,
   output logic [AW-1:0] raddr_alu,
   output logic [AW-1:0] waddr_alu,
   output logic          wen_alu,
   output logic          border,
   output logic          busy,
   output logic          done,
   output logic [1:0]    state_dbg
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      DRAIN   = 2'd2,
      DONE_ST = 2'd3
   } state_t;

   if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << AW)) begin : g_size_chk
      $error("conv_scan_ctrl: IMG_W*IMG_H does not fit in AW address bits");
   end

   state_t        state, state_n;
   logic [AW-1:0] addr;
   logic          last_px, edge_px, issue, clear;
   logic          wen_q, border_q;
   logic [AW-1:0] waddr_q;

   // Handshake: an address issues only in SCAN with stall low; stall holds every register in place.
   assign issue = (state == SCAN) && !stall;
   assign clear = (state == IDLE) && frame_start;

   scan_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) u_scan_counter (
      .clk     (CLK100MHZ),
      .rst_n   (rst_n),
      .clear   (clear),
      .en      (issue),
      .addr    (addr),
      .last_px (last_px),
      .edge_px (edge_px)
   );

   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (frame_start) state_n = SCAN;
         SCAN:    if (issue && last_px) state_n = DRAIN;
         DRAIN:   if (!stall) state_n = DONE_ST;
         DONE_ST: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // One-stage read pipeline: the write for an address lands the cycle after it issues.
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         border_q <= 1'b0;
      end else if (!stall) begin
         wen_q <= issue;
         if (issue) begin
            waddr_q  <= addr;
            border_q <= edge_px;
         end
      end
   end

   assign raddr_alu = addr;
   assign waddr_alu = waddr_q;
   assign wen_alu   = wen_q && !stall;
   assign border    = border_q && wen_alu;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE_ST);
   assign state_dbg = state;
endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Bench for conv_scan_ctrl: a 4x3 instance against a frame-level model, plus a full 320x240 frame in parallel.
module tb_conv_scan_ctrl;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int N  = W * H;
   localparam int AW = 17;
   localparam int BN = 320 * 240;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, frame_start, stall;
   logic [AW-1:0] raddr, waddr;
   logic          wen, border, busy, done;
   logic [1:0]    st_dbg;

   logic          rst_big, fs_big, stall_big;
   logic [AW-1:0] raddr_big, waddr_big;
   logic          wen_big, border_big, busy_big, done_big;
   logic [1:0]    st_dbg_big;

   conv_scan_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
      .CLK100MHZ(clk), .rst_n(rst_n), .frame_start(frame_start), .stall(stall),
      .raddr_alu(raddr), .waddr_alu(waddr), .wen_alu(wen), .border(border),
      .busy(busy), .done(done), .state_dbg(st_dbg)
   );

   conv_scan_ctrl dut_big (
      .CLK100MHZ(clk), .rst_n(rst_big), .frame_start(fs_big), .stall(stall_big),
      .raddr_alu(raddr_big), .waddr_alu(waddr_big), .wen_alu(wen_big), .border(border_big),
      .busy(busy_big), .done(done_big), .state_dbg(st_dbg_big)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   function automatic void chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic bit is_border(input int a);
      int x, y;
      x = a % W;
      y = a / W;
      return (x == 0) || (x == W - 1) || (y == 0) || (y == H - 1);
   endfunction

   // Frame-level model: phase 0 idle, 1 scanning, 2 last write outstanding, 3 done pulse.
   int phase = 0;
   int issue_idx = 0;
   bit pend_v = 1'b0;
   int pend_addr = 0;
   int log_addr[$];
   int log_cyc[$];
   bit log_border[$];
   int done_cyc = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_raddr", raddr, 0);
         chk("rst_wen", wen, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         phase  = 0;
         pend_v = 1'b0;
      end else begin
         chk("wen", wen, pend_v && !stall);
         chk("busy", busy, phase != 0);
         chk("done", done, phase == 3);
         if (pend_v && !stall) begin
            chk("waddr", waddr, pend_addr);
            chk("border", border, is_border(pend_addr));
         end else begin
            chk("border_idle", border, 0);
         end
         if (phase == 1) chk("raddr", raddr, issue_idx);
         if (wen) begin
            log_addr.push_back(int'(waddr));
            log_cyc.push_back(cyc);
            log_border.push_back(border);
         end
         if (done) begin
            done_cyc = cyc;
            done_cnt++;
         end
         case (phase)
            0: if (frame_start) begin phase = 1; issue_idx = 0; pend_v = 1'b0; end
            1: if (!stall) begin
                  pend_v    = 1'b1;
                  pend_addr = issue_idx;
                  if (issue_idx == N - 1) phase = 2;
                  else issue_idx++;
               end
            2: if (!stall) begin pend_v = 1'b0; phase = 3; end
            default: phase = 0;
         endcase
      end
   end

   task automatic clear_logs();
      log_addr.delete();
      log_cyc.delete();
      log_border.delete();
      done_cnt = 0;
   endtask

   // stall_addr >= 0 holds the write of that address for stall_len cycles.
   task automatic run_frame(input int stall_addr, input int stall_len, input bit rnd, input bit spam);
      int left = 0;
      bit seen = 1'b0;
      bit fin  = 1'b0;
      clear_logs();
      @(posedge clk); #1 frame_start = 1'b1; stall = 1'b0;
      @(posedge clk); #1 frame_start = 1'b0;
      for (int c = 0; c < 400 && !fin; c++) begin
         if (left > 0) begin
            stall = 1'b1;
            left--;
         end else if (stall_addr >= 0 && !seen && busy && int'(raddr) == stall_addr + 1) begin
            stall = 1'b1;
            left  = stall_len - 1;
            seen  = 1'b1;
         end else begin
            stall = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
         end
         if (done) begin
            fin = 1'b1;
            frame_start = spam;
         end else begin
            frame_start = spam ? ($urandom_range(0, 4) == 0) : 1'b0;
         end
         @(posedge clk); #1;
      end
      frame_start = 1'b0;
      stall = 1'b0;
      chk("frame_finished", fin, 1);
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic small_tests();
      logic [N-1:0] bv;
      int n;
      rst_n = 1'b0; frame_start = 1'b0; stall = 1'b0;
      @(posedge clk); #1;
      chk("rst_waddr", waddr, 0);
      chk("rst_border", border, 0);
      chk("rst_dbg", st_dbg, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Unstalled frame: 12 writes on consecutive cycles, interior pixels 5 and 6 only.
      run_frame(-1, 0, 1'b0, 1'b0);
      chk("f1_count", log_addr.size(), N);
      chk("f1_done_count", done_cnt, 1);
      if (log_addr.size() == N) begin
         bv = '0;
         for (int i = 0; i < N; i++) begin
            chk("f1_addr", log_addr[i], i);
            bv[i] = log_border[i];
         end
         chk("f1_border_map", bv, 12'hF9F);
         chk("f1_back_to_back", log_cyc[N-1] - log_cyc[0], N - 1);
         chk("f1_done_after_last", done_cyc, log_cyc[N-1] + 1);
      end

      // Stall three cycles while address 5 is the pending write.
      run_frame(5, 3, 1'b0, 1'b0);
      chk("f2_count", log_addr.size(), N);
      if (log_addr.size() == N) begin
         for (int i = 0; i < N; i++) chk("f2_addr", log_addr[i], i);
         chk("f2_gap_at_5", log_cyc[5] - log_cyc[4], 4);
      end

      // frame_start during SCAN and on the DONE cycle is ignored.
      run_frame(-1, 0, 1'b0, 1'b1);
      chk("f3_count", log_addr.size(), N);
      chk("f3_done_count", done_cnt, 1);

      for (int f = 0; f < 4; f++) begin
         run_frame(-1, 0, 1'b1, 1'b1);
         chk("rnd_count", log_addr.size(), N);
         chk("rnd_done_count", done_cnt, 1);
      end

      // Asynchronous reset while address 7 is being issued.
      clear_logs();
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
      n = 0;
      while (int'(raddr) != 7 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_reached_7", raddr, 7);
      #1 rst_n = 1'b0;
      #1;
      chk("async_raddr", raddr, 0);
      chk("async_waddr", waddr, 0);
      chk("async_wen", wen, 0);
      chk("async_border", border, 0);
      chk("async_busy", busy, 0);
      chk("async_done", done, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (wen) n++;
      end
      chk("post_reset_writes", n, 0);
      chk("post_reset_done", done_cnt, 0);
   endtask

   task automatic big_test();
      int cnt = 0, bad = 0, gaps = 0, dones = 0;
      longint last = -1;
      rst_big = 1'b0; fs_big = 1'b0; stall_big = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_big = 1'b1;
      @(posedge clk); #1 fs_big = 1'b1;
      @(posedge clk); #1 fs_big = 1'b0;
      for (int c = 0; c < 80000 && dones == 0; c++) begin
         @(negedge clk);
         if (!busy_big) gaps++;
         if (wen_big) begin
            if (int'(waddr_big) != cnt) bad++;
            last = waddr_big;
            cnt++;
         end
         if (done_big) dones++;
      end
      chk("big_writes", cnt, BN);
      chk("big_last_addr", last, BN - 1);
      chk("big_order_errors", bad, 0);
      chk("big_busy_gaps", gaps, 0);
      chk("big_done", dones, 1);
   endtask

   initial begin
      fork
         small_tests();
         big_test();
      join
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/conv_scan_ctrl.md
CONV_SCAN_CTRL -- requirements
Module: conv_scan_ctrl

Interface
REQ-001 Parameter IMG_W, default 320, frame width in pixels.
REQ-002 Parameter IMG_H, default 240, frame height in pixels.
REQ-003 Parameter AW, default 17, processing/frame buffer address width (equal to `awidth_pbuff` and `awidth_fbuff`).
REQ-004 CLK100MHZ  in  1  sole clock; all state on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 frame_start  in  1  single-cycle pulse, new frame ready in processing buffer.
REQ-007 stall  in  1  memory controller cannot accept ALU traffic this cycle.
REQ-008 raddr_alu  out  AW  window-centre read address, y*IMG_W+x.
REQ-009 waddr_alu  out  AW  frame buffer write address for the current ALU result.
REQ-010 wen_alu  out  1  write enable for wdata_alu.
REQ-011 border  out  1  current write is a border pixel; the top level forces wdata to 0.
REQ-012 busy  out  1  scan in progress.
REQ-013 done  out  1  single-cycle pulse after the last write of a frame.

Function
REQ-014 FSM states IDLE, SCAN, DRAIN, DONE; encoding is free.
REQ-015 IDLE->SCAN on frame_start; x and y are cleared to 0; busy=1 from the next cycle.
REQ-016 In SCAN, with stall=0, raddr_alu=y*IMG_W+x; x increments each cycle and wraps IMG_W-1->0 with y+1.
REQ-017 SCAN->DRAIN when x=IMG_W-1 and y=IMG_H-1 issue with stall=0.
REQ-018 Read latency is 1 cycle: an address issued in cycle t yields wen_alu=1 in t+1, with waddr_alu equal to that address.
REQ-019 border=1 alongside wen_alu when the issued x is 0 or IMG_W-1, or y is 0 or IMG_H-1; otherwise 0.
REQ-020 DRAIN lasts until the final write completes; then DONE for exactly 1 cycle (done=1), then IDLE.
REQ-021 stall=1 freezes x, y, raddr_alu, the pipeline register, and FSM state; wen_alu=0 while stall=1.
REQ-022 When stall deasserts, the held write issues with an unchanged address; no address is skipped or written twice.
REQ-023 frame_start is ignored when not in IDLE.
REQ-024 frame_start coincident with DONE is ignored; the controller returns to IDLE.
REQ-025 Exactly IMG_W*IMG_H writes occur per frame, in ascending address order.
REQ-026 The address multiply is avoided: a running linear address counter increments with x.
REQ-027 The address counter width is AW; IMG_W*IMG_H <= 2^AW is required, and is checked by an elaboration-time assertion.

Reset
REQ-028 rst_n=0 forces IDLE immediately, regardless of the clock.
REQ-029 During reset: x=y=0, raddr_alu=0, waddr_alu=0, wen_alu=0, border=0, busy=0, done=0.
REQ-030 Reset mid-frame aborts the scan; no further writes are issued, and done is not pulsed.

Structure
REQ-031 IMG_W, IMG_H and AW defaults are derived from the shared `my_header.vh` constants.
REQ-032 The FSM state encoding is a localparam inside the module.
REQ-033 One sub-module: scan_counter (x/y/linear address counters with enable and wrap).
REQ-034 The block is instantiated in the top level, driving raddr_alu/waddr_alu/wen_alu of mem_controller.

Verification
REQ-035 IMG_W=4, IMG_H=3, frame_start, no stall -> 12 writes at addresses 0..11 on consecutive cycles; border=1 except at addresses 5 and 6; done once, 1 cycle after the last write.
REQ-036 Same frame, stall=1 for 3 cycles at address 5 -> wen_alu=0 for 3 cycles, then address 5 written once; total still 12 writes.
REQ-037 frame_start pulsed during SCAN and on the DONE cycle -> ignored; exactly one frame of writes.
REQ-038 rst_n low asynchronously at address 7 -> outputs zero before the next edge; after release no writes occur until a new frame_start.
REQ-039 Default 320x240 -> 76800 writes; last waddr_alu=76799; busy high continuously from the cycle after frame_start until done.
